// File: rtl/io_input_dec_if.sv
// Bus port bundle for the IO input decoder: chip enable, byte address,
// write strobe and byte-swapped write/read data.
interface io_input_dec_if;
   logic        ce;
   logic [31:0] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;

   modport master (output ce, addr, we, din, input  dout);
   modport slave  (input  ce, addr, we, din, output dout);
endinterface

// File: rtl/io_input_dec.sv
// Debounced switch/button input block with a small memory-mapped register
// file (SW, BTN, EDGE w1c, IE) and a registered interrupt.

// One input bit: two-flop synchronizer, tick sample and stable-twice debounce.
module io_input_dec_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic deb
);
   logic [1:0] sync;
   logic       samp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         samp <= 1'b0;
         deb  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (tick) begin
            samp <= sync[1];
            if (sync[1] == samp) deb <= sync[1];
         end
      end
   end
endmodule

module io_input_dec #(
   parameter int DB_CYCLES = 100000
) (
   input  logic           clk,
   input  logic           rst_n,
   io_input_dec_if.slave  bus,
   input  logic [15:0]    sw,
   input  logic [4:0]     btn,
   output logic           irq
);
   localparam int NUM_LANES = 21;
   localparam int CW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [15:0] A_SW   = 16'hf020;
   localparam logic [15:0] A_BTN  = 16'hf024;
   localparam logic [15:0] A_EDGE = 16'hf028;
   localparam logic [15:0] A_IE   = 16'hf02c;

   function automatic logic [31:0] bswap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // debounce sample tick
   logic [CW-1:0] cnt;
   logic          tick;

   assign tick = (cnt == CW'(DB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

   // sw occupies lanes 15:0, btn lanes 20:16
   logic [NUM_LANES-1:0] raw;
   logic [NUM_LANES-1:0] deb;

   assign raw = {btn, sw};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      io_input_dec_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .tick  (tick),
         .raw   (raw[g]),
         .deb   (deb[g])
      );
   end

   logic [15:0] sw_deb;
   logic [4:0]  btn_deb;

   assign sw_deb  = deb[15:0];
   assign btn_deb = deb[20:16];

   // bus write decode
   logic [31:0] wdata;
   logic [15:0] a16;
   logic        wr;
   logic        wr_edge;
   logic        wr_ie;

   assign wdata   = bswap(bus.din);
   assign a16     = bus.addr[15:0];
   assign wr      = bus.ce & bus.we;
   assign wr_edge = wr && (a16 == A_EDGE);
   assign wr_ie   = wr && (a16 == A_IE);

   logic [4:0] btn_prev;
   logic [4:0] edge_q;
   logic [4:0] ie;
   logic [4:0] rise;
   logic [4:0] clr;

   assign rise = btn_deb & ~btn_prev;
   assign clr  = wr_edge ? wdata[4:0] : 5'b0;

   // a rise wins over a same-cycle w1c of that bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev <= '0;
         edge_q   <= '0;
         ie       <= '0;
         irq      <= 1'b0;
      end else begin
         btn_prev <= btn_deb;
         edge_q   <= (edge_q & ~clr) | rise;
         if (wr_ie) ie <= wdata[4:0];
         irq      <= |(edge_q & ie);
      end
   end

   // combinational, side-effect-free read path
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      if (bus.ce) begin
         case (a16)
            A_SW:    rdata = {16'b0, sw_deb};
            A_BTN:   rdata = {27'b0, btn_deb};
            A_EDGE:  rdata = {27'b0, edge_q};
            A_IE:    rdata = {27'b0, ie};
            default: rdata = '0;
         endcase
      end
   end

   assign bus.dout = bswap(rdata);

   logic unused_ok;
   assign unused_ok = ^{bus.addr[31:16], wdata[31:5]};
endmodule

// File: tb/tb_io_input_dec.sv
// Directed scenarios followed by random traffic, checked against a
// behavioural model of the debounce/register rules.
module tb_io_input_dec;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sw;
   logic [4:0]  btn;
   logic        irq;

   int vectors = 0;
   int errors  = 0;

   io_input_dec_if bus ();

   io_input_dec #(.DB_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .sw    (sw),
      .btn   (btn),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          m_cnt;
   logic [20:0] m_pipe [2];   // raw inputs seen one and two edges ago
   logic [20:0] m_samp, m_deb;
   logic [4:0]  m_prev, m_edge, m_ie;
   logic        m_irq;

   function automatic logic [31:0] swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_pipe[0] = '0; m_pipe[1] = '0;
      m_samp = '0; m_deb = '0; m_prev = '0; m_edge = '0; m_ie = '0; m_irq = 1'b0;
   endtask

   task automatic model_update();
      logic [20:0] synced;
      logic        tick;
      logic [31:0] wd;
      logic        wr;
      logic [4:0]  rise;
      synced = m_pipe[1];
      tick   = (m_cnt == DB - 1);
      wd     = swap(bus.din);
      wr     = bus.ce && bus.we;
      rise   = m_deb[20:16] & ~m_prev;
      m_irq  = |(m_edge & m_ie);
      if (wr && bus.addr[15:0] == 16'hf028) m_edge = m_edge & ~wd[4:0];
      m_edge = m_edge | rise;
      if (wr && bus.addr[15:0] == 16'hf02c) m_ie = wd[4:0];
      m_prev = m_deb[20:16];
      if (tick) begin
         for (int i = 0; i < 21; i++)
            if (synced[i] == m_samp[i]) m_deb[i] = synced[i];
         m_samp = synced;
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {btn, sw};
      m_cnt     = (m_cnt + 1) % DB;
   endtask

   function automatic logic [31:0] model_read();
      logic [31:0] r;
      r = '0;
      if (bus.ce) begin
         case (bus.addr[15:0])
            16'hf020: r = {16'b0, m_deb[15:0]};
            16'hf024: r = {27'b0, m_deb[20:16]};
            16'hf028: r = {27'b0, m_edge};
            16'hf02c: r = {27'b0, m_ie};
            default:  r = '0;
         endcase
      end
      return swap(r);
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_update();
      @(negedge clk);
      check("dout_vs_model", bus.dout, model_read());
      check("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic read_chk(input string tag, input logic [15:0] a, input logic [31:0] exp_int);
      logic [15:0] hi;
      hi = 16'($urandom);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = {hi, a};
      #1;
      check(tag, bus.dout, swap(exp_int));
      check({tag, "_model"}, bus.dout, model_read());
   endtask

   task automatic bus_write(input logic c, input logic [15:0] a, input logic [31:0] d_int);
      bus.ce = c; bus.we = 1'b1; bus.addr = {16'h0, a}; bus.din = swap(d_int);
   endtask

   task automatic bus_idle();
      bus.we = 1'b0; bus.din = '0;
   endtask

   initial begin
      logic        seen;
      logic [31:0] v;
      rst_n = 1'b0; sw = '0; btn = '0;
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h0000f028; bus.din = '0;
      model_reset();
      #1;
      check("rst_edge", bus.dout, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      read_chk("rst_ie", 16'hf02c, 32'h0);
      read_chk("rst_sw", 16'hf020, 32'h0);

      // stable switches: visible only after the second agreeing tick
      @(negedge clk);
      rst_n = 1'b1;
      sw = 16'h00a5;
      for (int i = 0; i < 7; i++) step();
      read_chk("sw_early", 16'hf020, 32'h0);
      step();
      read_chk("sw_a5", 16'hf020, 32'h000000a5);
      check("sw_a5_bus", bus.dout, 32'ha5000000);

      // 3-cycle glitch on btn[0] straddling one tick
      step();
      btn = 5'h01;
      for (int i = 0; i < 3; i++) step();
      btn = 5'h00;
      for (int i = 0; i < 8; i++) step();
      read_chk("glitch_btn", 16'hf024, 32'h0);
      read_chk("glitch_edge", 16'hf028, 32'h0);
      check("glitch_irq", {31'b0, irq}, 32'h0);

      // IE enable, held button -> edge then irq one cycle later
      bus_write(1'b1, 16'hf02c, 32'h1);
      check("ie_din_bus", bus.din, 32'h01000000);
      step();
      bus_idle();
      read_chk("ie_set", 16'hf02c, 32'h1);
      btn = 5'h01;
      bus.addr = 32'h0000f028;
      seen = 1'b0;
      for (int i = 0; i < 6 * DB + 6 && !seen; i++) begin
         step();
         if (bus.dout === 32'h01000000) seen = 1'b1;
      end
      check("edge0_seen", {31'b0, seen}, 32'h1);
      check("irq_lags_edge", {31'b0, irq}, 32'h0);
      step();
      check("irq_set", {31'b0, irq}, 32'h1);
      bus_write(1'b1, 16'hf028, 32'h1);
      step();
      bus_idle();
      read_chk("edge0_cleared", 16'hf028, 32'h0);
      step();
      check("irq_cleared", {31'b0, irq}, 32'h0);

      // w1c of bit 2 on the very edge that sets it
      btn = 5'h05;
      bus.addr = 32'h0000f024;
      seen = 1'b0;
      for (int i = 0; i < 6 * DB + 6 && !seen; i++) begin
         step();
         v = swap(bus.dout);
         if (v[2]) seen = 1'b1;
      end
      check("btn2_deb_seen", {31'b0, seen}, 32'h1);
      read_chk("edge2_pre", 16'hf028, 32'h0);
      bus_write(1'b1, 16'hf028, 32'h4);
      step();
      bus_idle();
      read_chk("edge2_set_wins", 16'hf028, 32'h4);

      // ce=0 accesses and read-only/unmapped writes
      bus_write(1'b0, 16'hf02c, 32'h1f);
      step();
      bus_idle();
      bus.ce = 1'b0; bus.addr = 32'h0000f020;
      #1;
      check("ce0_read", bus.dout, 32'h0);
      read_chk("ce0_ie_kept", 16'hf02c, 32'h1);
      bus_write(1'b1, 16'hf020, 32'h0000ffff);
      step();
      bus_write(1'b1, 16'hf034, 32'h0000001f);
      step();
      bus_idle();
      read_chk("ro_sw_kept", 16'hf020, 32'h000000a5);
      read_chk("ro_edge_kept", 16'hf028, 32'h4);
      read_chk("unmapped_rd", 16'hf030, 32'h0);

      // asynchronous reset mid-debounce
      btn = 5'h1f;
      for (int i = 0; i < 5; i++) step();
      bus.addr = 32'h0000f02c;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_ie", bus.dout, 32'h0);
      check("arst_irq", {31'b0, irq}, 32'h0);
      read_chk("arst_edge", 16'hf028, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      read_chk("arst_edge_early", 16'hf028, 32'h0);
      step();
      read_chk("arst_edge_1f", 16'hf028, 32'h1f);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 20) == 0) sw = 16'($urandom);
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 23) == 0) btn[b] = ~btn[b];
         bus.ce = ($urandom_range(0, 7) != 0);
         bus.we = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0: bus.addr = {16'($urandom), 16'hf020};
            1: bus.addr = {16'($urandom), 16'hf024};
            2: bus.addr = {16'($urandom), 16'hf028};
            3: bus.addr = {16'($urandom), 16'hf02c};
            4: bus.addr = {16'($urandom), 16'hf030};
            default: bus.addr = $urandom;
         endcase
         bus.din = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
